eth_stats_stream_arbiter: RTL

Shares a single 64-bit AXI4-Stream output between `num_ports` Ethernet statistics sources, each presenting one 448-bit snapshot record (time, tx_bytes, tx_good, tx_bad, rx_bytes, rx_good, rx_bad). A round-robin arbiter grants one source at a time, pops its record, and serializes it as an 8-beat packet: one header followed by seven payload words. The block sits between the per-port statistics collectors and the DMA/stream path that carries samples to the host.

---
 rtl/eth_stats_stream_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/eth_stats_stream_arbiter.sv
// Round-robin arbiter that pops one 448-bit statistics record per grant and
// streams it as an 8-beat AXI4-Stream packet (header + seven 64-bit fields).
module eth_stats_stream_arbiter #(
   parameter int unsigned num_ports = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic [num_ports-1:0]     req_valid,
   input  logic [448*num_ports-1:0] req_data,
   output logic [num_ports-1:0]     req_pop,
   output logic [63:0]              m_axis_tdata,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic                     m_axis_tlast,
   output logic [15:0]              seq_num,
   output logic                     busy
);

   localparam int unsigned PW = (num_ports > 1) ? $clog2(num_ports) : 1;

   typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] last_grant_q, last_grant_d;
   logic [3:0]    port_q, port_d;
   logic [447:0]  hold_q, hold_d;
   logic [2:0]    word_q, word_d;
   logic [15:0]   seq_q, seq_d;

   logic          grant_found;
   int unsigned   grant_idx;
   int unsigned   cand;
   int unsigned   field_idx;

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = 0;
      cand        = 0;
      for (int unsigned k = 1; k <= num_ports; k++) begin
         cand = (32'(last_grant_q) + k) % num_ports;
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      port_d        = port_q;
      hold_d        = hold_q;
      word_d        = word_q;
      seq_d         = seq_q;
      req_pop       = '0;
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      field_idx     = 32'd6 - 32'(word_q);
      unique case (state_q)
         IDLE: begin
            // pop is combinational, so it is also held off while reset is asserted
            if (rst_n && enable && grant_found) begin
               req_pop[grant_idx] = 1'b1;
               hold_d             = req_data[grant_idx*448 +: 448];
               last_grant_d       = PW'(grant_idx);
               port_d             = 4'(grant_idx);
               state_d            = HEADER;
            end
         end
         HEADER: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = {8'hA5, 4'd0, port_q, seq_q, 32'd0};
            if (m_axis_tready) begin
               word_d  = '0;
               state_d = PAYLOAD;
            end
         end
         PAYLOAD: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = hold_q[field_idx*64 +: 64];
            m_axis_tlast  = (word_q == 3'd6);
            if (m_axis_tready) begin
               if (word_q == 3'd6) begin
                  seq_d   = seq_q + 16'd1;
                  state_d = IDLE;
               end else begin
                  word_d = word_q + 3'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= PW'(num_ports - 1);
         port_q       <= '0;
         hold_q       <= '0;
         word_q       <= '0;
         seq_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         port_q       <= port_d;
         hold_q       <= hold_d;
         word_q       <= word_d;
         seq_q        <= seq_d;
      end
   end

   assign seq_num = seq_q;
   assign busy    = (state_q != IDLE);

endmodule
